// File: rtl/edge_pkg.sv
// Shared types and defaults for the Sobel edge pipeline: pixel/window shapes,
// gradient and magnitude widths, and the per-stage pipeline records.
package edge_pkg;

  localparam int unsigned FRAME_WIDTH_DEF  = 320;
  localparam int unsigned FRAME_HEIGHT_DEF = 240;
  localparam int unsigned ADDR_W           = 17;
  localparam int unsigned PIX_W            = 4;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef pixel_t [2:0][2:0] window_t;   // [row][col], col 2 is the newest column
  typedef logic signed [6:0] grad_t;     // -60..+60
  typedef logic [6:0]        mag_t;      // 0..120
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    grad_t gx;
    grad_t gy;
    logic  border;
    logic  last;
    addr_t addr;
  } s1_t;

  typedef struct packed {
    logic  valid;
    mag_t  mag;
    logic  border;
    logic  last;
    addr_t addr;
  } s2_t;

  function automatic mag_t abs_grad(grad_t g);
    return g[6] ? mag_t'(-g) : mag_t'(g);
  endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational Sobel gradients of one 3x3 window of 4-bit pixels.
module sobel_kernel
  import edge_pkg::*;
(
  input  window_t win,
  output grad_t   gx,
  output grad_t   gy
);

  // 1-2-1 weighted tap sum; at most 60, so the 7-bit difference cannot wrap.
  function automatic mag_t tap_sum(pixel_t a, pixel_t b, pixel_t c);
    return mag_t'(a) + (mag_t'(b) << 1) + mag_t'(c);
  endfunction

  always_comb begin
    gx = $signed(tap_sum(win[0][2], win[1][2], win[2][2])
               - tap_sum(win[0][0], win[1][0], win[2][0]));
    gy = $signed(tap_sum(win[2][0], win[2][1], win[2][2])
               - tap_sum(win[0][0], win[0][1], win[0][2]));
  end

endmodule

// File: rtl/sobel_edge_pipeline.sv
// Three-stage Sobel edge pipeline: gradients, magnitude, then threshold/scale
// with frame-buffer addressing and a per-frame edge-pixel count.
module sobel_edge_pipeline
  import edge_pkg::*;
#(
  parameter int unsigned THRESHOLD    = 24,
  parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int unsigned FRAME_HEIGHT = FRAME_HEIGHT_DEF
) (
  input  logic       mainClk,
  input  logic       reset,
  input  window_t    pixelData,
  input  logic       pixelDataValid,
  input  logic [9:0] spiXVal,
  input  logic [8:0] spiYVal,
  output logic [3:0] edgeData,
  output logic       edgeBit,
  output logic       edgeValid,
  output addr_t      edgeAddr,
  output logic       frameDone,
  output addr_t      edgeCount
);

  grad_t       gx, gy;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;
  logic [3:0]  edge_data_d, edge_data_q;
  logic        edge_bit_d, edge_bit_q;
  logic        edge_valid_d, edge_valid_q;
  addr_t       edge_addr_d, edge_addr_q;
  logic        frame_done_d, frame_done_q;
  addr_t       edge_count_d, edge_count_q;
  addr_t       run_count_d, run_count_q;
  addr_t       run_inc;
  logic [31:0] x_w, y_w;
  mag_t        scaled;

  sobel_kernel u_kernel (
    .win (pixelData),
    .gx  (gx),
    .gy  (gy)
  );

  always_comb begin
    // NOTE: each target is defaulted before any branch, so no path can infer a latch.
    s1_d         = s1_q;
    s2_d         = s2_q;
    edge_data_d  = edge_data_q;
    edge_bit_d   = edge_bit_q;
    edge_addr_d  = edge_addr_q;
    x_w          = 32'(spiXVal);
    y_w          = 32'(spiYVal);

    // Column 0 has no column to its left, so there is no window centre to emit.
    s1_d.valid = pixelDataValid && (spiXVal != '0);
    if (s1_d.valid) begin
      s1_d.gx     = gx;
      s1_d.gy     = gy;
      s1_d.border = (x_w < 2) || (x_w >= FRAME_WIDTH) || (y_w == 0) || (y_w >= FRAME_HEIGHT - 1);
      s1_d.last   = (x_w == FRAME_WIDTH - 1) && (y_w == FRAME_HEIGHT - 1);
      s1_d.addr   = addr_t'(y_w * FRAME_WIDTH + x_w - 1);
    end

    s2_d.valid = s1_q.valid;
    if (s1_q.valid) begin
      s2_d.mag    = abs_grad(s1_q.gx) + abs_grad(s1_q.gy);
      s2_d.border = s1_q.border;
      s2_d.last   = s1_q.last;
      s2_d.addr   = s1_q.addr;
    end

    scaled       = s2_q.mag >> 3;
    edge_valid_d = s2_q.valid;
    frame_done_d = s2_q.valid && s2_q.last;
    if (s2_q.valid) begin
      edge_bit_d  = !s2_q.border && (32'(s2_q.mag) >= THRESHOLD);
      edge_data_d = s2_q.border ? 4'd0 : ((scaled > 7'd15) ? 4'd15 : scaled[3:0]);
      edge_addr_d = s2_q.addr;
    end

    // The closing pixel of a frame is counted before the total is published.
    run_inc = run_count_q;
    if (edge_valid_d && edge_bit_d && (run_count_q != '1)) begin
      run_inc = run_count_q + 1'b1;
    end
    run_count_d  = frame_done_d ? '0 : run_inc;
    edge_count_d = frame_done_d ? run_inc : edge_count_q;
  end

  always_ff @(posedge mainClk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values.
    if (reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      edge_data_q  <= '0;
      edge_bit_q   <= 1'b0;
      edge_valid_q <= 1'b0;
      edge_addr_q  <= '0;
      frame_done_q <= 1'b0;
      edge_count_q <= '0;
      run_count_q  <= '0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      edge_data_q  <= edge_data_d;
      edge_bit_q   <= edge_bit_d;
      edge_valid_q <= edge_valid_d;
      edge_addr_q  <= edge_addr_d;
      frame_done_q <= frame_done_d;
      edge_count_q <= edge_count_d;
      run_count_q  <= run_count_d;
    end
  end

  assign edgeData  = edge_data_q;
  assign edgeBit   = edge_bit_q;
  assign edgeValid = edge_valid_q;
  assign edgeAddr  = edge_addr_q;
  assign frameDone = frame_done_q;
  assign edgeCount = edge_count_q;

endmodule

// File: tb/tb_sobel_edge_pipeline.sv
// Self-checking bench for sobel_edge_pipeline: directed vector table, reset
// flush, and scoreboarded frames against an arithmetic reference model.
module tb_sobel_edge_pipeline;
  import edge_pkg::*;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int TH = 24;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  window_t    pix   = '0;
  logic       pix_v = 1'b0;
  logic [9:0] xv    = '0;
  logic [8:0] yv    = '0;
  logic [3:0] edgeData;
  logic       edgeBit, edgeValid, frameDone;
  addr_t      edgeAddr, edgeCount;

  sobel_edge_pipeline #(
    .THRESHOLD    (TH),
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H)
  ) dut (
    .mainClk        (clk),
    .reset          (rst),
    .pixelData      (pix),
    .pixelDataValid (pix_v),
    .spiXVal        (xv),
    .spiYVal        (yv),
    .edgeData       (edgeData),
    .edgeBit        (edgeBit),
    .edgeValid      (edgeValid),
    .edgeAddr       (edgeAddr),
    .frameDone      (frameDone),
    .edgeCount      (edgeCount)
  );

  always #5 clk = ~clk;

  int n_checks    = 0;
  int n_fail      = 0;
  int cyc         = 0;
  bit mon_en      = 1'b0;
  int frames_seen = 0;
  int run_cnt     = 0;
  int exp_count   = 0;

  typedef struct {
    int          due;
    logic [3:0]  data;
    logic        ebit;
    logic [16:0] addr;
    logic        last;
  } exp_t;

  typedef struct {
    window_t     w;
    int          x;
    int          y;
    logic        ev;
    logic [3:0]  ed;
    logic        eb;
    logic [16:0] ea;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic window_t win_cols(input int a, input int b, input int c);
    window_t w;
    for (int r = 0; r < 3; r++) begin
      w[r][0] = 4'(a);
      w[r][1] = 4'(b);
      w[r][2] = 4'(c);
    end
    return w;
  endfunction

  function automatic window_t win_px(input int r, input int c, input int v);
    window_t w;
    w = '0;
    w[r][c] = 4'(v);
    return w;
  endfunction

  function automatic window_t rand_win();
    window_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = 4'($urandom_range(0, 15));
    return w;
  endfunction

  // Reference: Sobel arithmetic on plain integers, then border/threshold rules.
  function automatic exp_t model(input window_t w, input int x, input int y);
    exp_t e;
    int   p[3][3];
    int   gx, gy, mag, sc;
    bit   border;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(w[r][c]);
    gx     = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy     = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    mag    = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    border = (x < 2) || (x > W - 1) || (y == 0) || (y >= H - 1);
    sc     = (mag / 8 > 15) ? 15 : mag / 8;
    e.due  = 0;
    e.ebit = !border && (mag >= TH);
    e.data = border ? 4'd0 : 4'(sc);
    e.addr = 17'(y * W + x - 1);
    e.last = (x == W - 1) && (y == H - 1);
    return e;
  endfunction

  // Scoreboard monitor: every cycle either the next expected output is due or a bubble.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mon_en) begin
      if (frameDone) frames_seen++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("sb_valid", edgeValid, 1);
        check("sb_data", edgeData, mon_e.data);
        check("sb_bit", edgeBit, mon_e.ebit);
        check("sb_addr", edgeAddr, mon_e.addr);
        check("sb_frame_done", frameDone, mon_e.last);
        if (mon_e.ebit && run_cnt < 131071) run_cnt++;
        if (mon_e.last) begin
          exp_count = run_cnt;
          run_cnt   = 0;
        end
      end else begin
        check("sb_bubble_valid", edgeValid, 0);
        check("sb_bubble_frame_done", frameDone, 0);
      end
      check("sb_edge_count", edgeCount, exp_count);
    end
  end

  task automatic send(input window_t w, input int x, input int y);
    exp_t e;
    @(negedge clk);
    pix   = w;
    xv    = 10'(x);
    yv    = 9'(y);
    pix_v = 1'b1;
    if (mon_en && x != 0) begin
      e     = model(w, x, y);
      e.due = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_v = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    pix_v = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    run_cnt   = 0;
    exp_count = 0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    pix   = v.w;
    xv    = 10'(v.x);
    yv    = 9'(v.y);
    pix_v = 1'b1;
    @(negedge clk);
    pix_v = 1'b0;
    @(posedge clk); #1;
    check($sformatf("vec%0d_early", idx), edgeValid, 0);
    @(posedge clk); #1;
    check($sformatf("vec%0d_valid", idx), edgeValid, v.ev);
    if (v.ev) begin
      check($sformatf("vec%0d_data", idx), edgeData, v.ed);
      check($sformatf("vec%0d_bit", idx), edgeBit, v.eb);
      check($sformatf("vec%0d_addr", idx), edgeAddr, v.ea);
    end
    @(posedge clk); #1;
    check($sformatf("vec%0d_strobe", idx), edgeValid, 0);
    if (v.ev) check($sformatf("vec%0d_hold", idx), edgeData, v.ed);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, edgeData, 0);
    check({tag, "_bit"}, edgeBit, 0);
    check({tag, "_valid"}, edgeValid, 0);
    check({tag, "_addr"}, edgeAddr, 0);
    check({tag, "_frame_done"}, frameDone, 0);
    check({tag, "_count"}, edgeCount, 0);
  endtask

  initial begin
    window_t step_win, mag90_win;
    int      x, y;

    step_win  = win_cols(0, 9, 15);
    mag90_win = '0;
    mag90_win[1][2] = 4'd15;
    mag90_win[2][2] = 4'd15;
    mag90_win[2][1] = 4'd15;

    tbl[0]  = '{win_cols(7, 7, 7), 5,   10,  1'b1, 4'd0,  1'b0, 17'd3204};
    tbl[1]  = '{step_win,          100, 50,  1'b1, 4'd7,  1'b1, 17'd16099};
    tbl[2]  = '{step_win,          1,   50,  1'b1, 4'd0,  1'b0, 17'd16000};
    tbl[3]  = '{step_win,          0,   50,  1'b0, 4'd0,  1'b0, 17'd0};
    tbl[4]  = '{step_win,          100, 0,   1'b1, 4'd0,  1'b0, 17'd99};
    tbl[5]  = '{step_win,          100, 239, 1'b1, 4'd0,  1'b0, 17'd76579};
    tbl[6]  = '{step_win,          320, 50,  1'b1, 4'd0,  1'b0, 17'd16319};
    tbl[7]  = '{step_win,          100, 300, 1'b1, 4'd0,  1'b0, 17'd96099};
    tbl[8]  = '{win_px(1, 2, 11),  10,  5,   1'b1, 4'd2,  1'b0, 17'd1609};
    tbl[9]  = '{win_px(1, 2, 12),  10,  5,   1'b1, 4'd3,  1'b1, 17'd1609};
    tbl[10] = '{mag90_win,         319, 238, 1'b1, 4'd11, 1'b1, 17'd76478};
    tbl[11] = '{step_win,          2,   1,   1'b1, 4'd7,  1'b1, 17'd321};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) apply_vec(tbl[i], i);

    // Three valid samples with reset landing on the second: nothing may emerge.
    @(negedge clk);
    pix = step_win; xv = 10'd100; yv = 9'd50; pix_v = 1'b1;
    @(negedge clk);
    rst = 1'b1; xv = 10'd101;
    @(negedge clk);
    xv = 10'd102;
    @(negedge clk);
    rst = 1'b0; pix_v = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("rst_flush_valid", edgeValid, 0);
    end
    check_reset_values("rst_flush");
    apply_vec(tbl[1], 100);

    // Frame 1: ten edge windows among flat ones, closed by the last pixel.
    do_reset();
    mon_en = 1'b1;
    idle(2);
    for (int i = 0; i < 10; i++) begin
      send(win_cols(3, 3, 3), 30 + i * 25, 40 + i * 15);
      send(step_win,          31 + i * 25, 40 + i * 15);
      if (i % 2 == 1) idle(1);
    end
    send(step_win, W - 1, H - 1);
    idle(6);
    check("frame1_count", edgeCount, 10);
    check("frame1_done", frames_seen, 1);
    check("frame1_drain", sb.size(), 0);

    // Frame 2: back-to-back alternating windows, then randomized traffic.
    for (int i = 0; i < 8; i++) send((i % 2 == 1) ? step_win : win_cols(0, 0, 0), 10 + i, 20);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 330);
        y = ($urandom_range(0, 9) == 0) ? $urandom_range(236, 300) : $urandom_range(0, 239);
        if (x == W - 1 && y == H - 1) x = W - 2;
        send(rand_win(), x, y);
      end
    end
    send(rand_win(), W - 1, H - 1);
    idle(6);
    check("frame2_count", edgeCount, exp_count);
    check("frame2_done", frames_seen, 2);
    check("frame2_drain", sb.size(), 0);

    // Frame 3: the count must restart from zero.
    for (int i = 0; i < 3; i++) send(step_win, 50 + i, 60);
    send(win_cols(0, 0, 0), W - 1, H - 1);
    idle(6);
    check("frame3_count", edgeCount, 3);
    check("frame3_done", frames_seen, 3);
    check("frame3_drain", sb.size(), 0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
